disp_scan: RTL and testbench

Time-multiplexed 4-digit scanner that drives the 7-segment decoder stage. It holds a 16-bit hex/BCD display word and steps through its nibbles at a programmable refresh rate. For the selected digit it presents the nibble on `w,x,y,z` (decoder inputs) and drives a one-hot digit-enable. New display words are committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/disp_pkg.sv | 10 +
 rtl/disp_scan.sv | 95 +++++++++
 tb/tb_disp_scan.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the 4-digit display scanner and the one-hot digit-select helper.
package disp_pkg;
  localparam int NDIG    = 4;
  localparam int DIV_SYN = 50000;
  localparam int DIV_SIM = 4;

  function automatic logic [NDIG-1:0] digit_onehot(input logic [1:0] idx);
    digit_onehot = NDIG'(1) << idx;
  endfunction
endpackage

// File: rtl/disp_scan.sv
// Time-multiplexed 4-digit scanner: prescaled digit stepping, frame-aligned word commit,
// and leading-zero blanking ahead of the 7-segment decoder.
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIV = DIV_SYN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     data_in,
  input  logic [NDIG-1:0] dp_in,
  input  logic            load,
  input  logic            blank_lz,
  output logic            w,
  output logic            x,
  output logic            y,
  output logic            z,
  output logic            dp,
  output logic [NDIG-1:0] digit_sel,
  output logic            pending
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            tick;
  logic            wrap;
  logic [15:0]     active;
  logic [15:0]     pend;
  logic [NDIG-1:0] active_dp;
  logic [NDIG-1:0] pend_dp;
  logic [NDIG-1:0] lz_mask;
  logic            blanked;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load landing on the wrap edge goes straight to the display and drops any staged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      active_dp <= '0;
      pend      <= '0;
      pend_dp   <= '0;
      pending   <= 1'b0;
    end else if (load && wrap) begin
      active    <= data_in;
      active_dp <= dp_in;
      pending   <= 1'b0;
    end else if (load) begin
      pend      <= data_in;
      pend_dp   <= dp_in;
      pending   <= 1'b1;
    end else if (wrap && pending) begin
      active    <= pend;
      active_dp <= pend_dp;
      pending   <= 1'b0;
    end
  end

  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (active[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (active[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (active[7:4] == 4'h0);
  end

  assign blanked = blank_lz && lz_mask[idx];

  always_comb begin
    {w, x, y, z} = 4'h0;
    dp           = 1'b0;
    digit_sel    = '0;
    if (!blanked) begin
      {w, x, y, z} = active[{idx, 2'b00} +: 4];
      dp           = active_dp[idx];
      digit_sel    = digit_onehot(idx);
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan: directed frame sequences, a blanking vector table,
// and randomized traffic against a time-based reference model.
module tb_disp_scan;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        w, x, y, z, dp, pending;
  logic [3:0]  digit_sel;

  disp_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .w(w), .x(x), .y(y), .z(z), .dp(dp),
    .digit_sel(digit_sel), .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time since reset release plus displayed word and a queue of staged words.
  int          t;
  logic [15:0] m_active;
  logic [3:0]  m_adp;
  logic [19:0] staged[$];

  typedef struct {
    logic [15:0] word;
    logic [3:0]  dpv;
    logic        blz;
    int          slot;
    logic [3:0]  sel;
    logic [3:0]  nib;
    logic        dpo;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] d, input logic [3:0] p);
    bit wr;
    wr = ((t % FRAME) == FRAME - 1);
    if (ld && wr) begin
      m_active = d;
      m_adp    = p;
      staged.delete();
    end else if (ld) begin
      staged.push_back({p, d});
    end else if (wr && staged.size() > 0) begin
      {m_adp, m_active} = staged[$];
      staged.delete();
    end
    t++;
  endtask

  task automatic check_model();
    int       slot;
    bit       blk;
    logic [3:0] e_sel, e_nib;
    logic       e_dp;
    slot = (t / DIV) % 4;
    blk  = blank_lz && slot > 0 && (32'(m_active) < (32'h1 << (4 * slot)));
    e_sel = blk ? 4'b0000 : 4'(1 << slot);
    e_nib = blk ? 4'h0 : 4'((m_active >> (4 * slot)) & 16'hF);
    e_dp  = blk ? 1'b0 : m_adp[slot];
    chk("model_sel", digit_sel, e_sel);
    chk("model_nib", {w, x, y, z}, e_nib);
    chk("model_dp", dp, e_dp);
    chk("model_pending", pending, staged.size() != 0);
  endtask

  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p);
    load    = ld;
    data_in = d;
    dp_in   = p;
    @(posedge clk);
    model_edge(ld, d, p);
    #1;
    load = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_sel", digit_sel, 4'b0001);
    chk("rst_nib", {w, x, y, z}, 4'h0);
    chk("rst_dp", dp, 1'b0);
    chk("rst_pending", pending, 1'b0);
    t        = 0;
    m_active = '0;
    m_adp    = '0;
    staged.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model();
  endtask

  initial begin
    int na;
    logic [15:0] r;

    tbl[0]  = '{16'h0030, 4'b0000, 1'b1, 0, 4'b0001, 4'h0, 1'b0};
    tbl[1]  = '{16'h0030, 4'b0000, 1'b1, 1, 4'b0010, 4'h3, 1'b0};
    tbl[2]  = '{16'h0030, 4'b0000, 1'b1, 2, 4'b0000, 4'h0, 1'b0};
    tbl[3]  = '{16'h0030, 4'b0000, 1'b1, 3, 4'b0000, 4'h0, 1'b0};
    tbl[4]  = '{16'h0000, 4'b0000, 1'b1, 0, 4'b0001, 4'h0, 1'b0};
    tbl[5]  = '{16'h0000, 4'b0000, 1'b1, 1, 4'b0000, 4'h0, 1'b0};
    tbl[6]  = '{16'h0000, 4'b0000, 1'b1, 3, 4'b0000, 4'h0, 1'b0};
    tbl[7]  = '{16'h0012, 4'b0100, 1'b1, 2, 4'b0000, 4'h0, 1'b0};
    tbl[8]  = '{16'h0012, 4'b0100, 1'b1, 1, 4'b0010, 4'h1, 1'b0};
    tbl[9]  = '{16'h0012, 4'b0100, 1'b1, 0, 4'b0001, 4'h2, 1'b0};
    tbl[10] = '{16'hA5F0, 4'b1010, 1'b0, 3, 4'b1000, 4'hA, 1'b1};
    tbl[11] = '{16'hA5F0, 4'b1010, 1'b0, 1, 4'b0010, 4'hF, 1'b1};
    tbl[12] = '{16'hA5F0, 4'b1010, 1'b0, 0, 4'b0001, 4'h0, 1'b0};
    tbl[13] = '{16'h0000, 4'b1000, 1'b0, 3, 4'b1000, 4'h0, 1'b1};
    tbl[14] = '{16'h0C00, 4'b0000, 1'b1, 3, 4'b0000, 4'h0, 1'b0};
    tbl[15] = '{16'h0C00, 4'b0000, 1'b1, 2, 4'b0100, 4'hC, 1'b0};

    // Reset release and slot stepping
    do_reset();
    chk("rel_sel_c0", digit_sel, 4'b0001);
    for (int c = 1; c <= 16; c++) begin
      step(1'b0, 16'h0, 4'h0);
      if (c < 4)   chk("rel_sel_early", digit_sel, 4'b0001);
      if (c == 4)  chk("rel_sel_c4", digit_sel, 4'b0010);
      if (c == 16) chk("rel_sel_c16", digit_sel, 4'b0001);
    end

    // Mid-frame load of 1234
    while (t < 48) begin
      step(t == 18, 16'h1234, 4'h0);
      if (t == 19 || t == 31) chk("l1234_pend_hi", pending, 1'b1);
      if (t == 32) begin
        chk("l1234_pend_lo", pending, 1'b0);
        chk("l1234_d0", {w, x, y, z}, 4'h4);
      end
      if (t == 36) chk("l1234_d1", {w, x, y, z}, 4'h3);
      if (t == 40) chk("l1234_d2", {w, x, y, z}, 4'h2);
      if (t == 44) begin
        chk("l1234_d3", {w, x, y, z}, 4'h1);
        chk("l1234_sel3", digit_sel, 4'b1000);
      end
    end

    // Two loads in one frame: last wins
    na = 0;
    while (t < 80) begin
      if (t == 50)      step(1'b1, 16'hAAAA, 4'h0);
      else if (t == 53) step(1'b1, 16'hBEEF, 4'h0);
      else              step(1'b0, 16'h0, 4'h0);
      if ({w, x, y, z} == 4'hA) na++;
      if (t == 64) chk("beef_d0", {w, x, y, z}, 4'hF);
      if (t == 68) chk("beef_d1", {w, x, y, z}, 4'hE);
      if (t == 76) chk("beef_d3", {w, x, y, z}, 4'hB);
    end
    chk("aaaa_never_shown", na, 0);

    // Load coincident with wrap
    while (t < 95) step(1'b0, 16'h0, 4'h0);
    chk("wrapload_pre_pend", pending, 1'b0);
    step(1'b1, 16'h5678, 4'h0);
    chk("wrapload_d0", {w, x, y, z}, 4'h8);
    chk("wrapload_pend", pending, 1'b0);

    // Reset in slot 2 with a staged word
    while (t < 105) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h9999, 4'h0);
    chk("midrst_pend_before", pending, 1'b1);
    chk("midrst_slot2", digit_sel, 4'b0100);
    #2;
    do_reset();
    while (t < 17) step(1'b0, 16'h0, 4'h0);
    chk("midrst_no_commit", {w, x, y, z}, 4'h0);
    chk("midrst_pend_after", pending, 1'b0);

    // Blanking vector table, each word committed on a wrap edge
    for (int i = 0; i < 16; i++) begin
      while ((t % FRAME) != FRAME - 1) step(1'b0, 16'h0, 4'h0);
      blank_lz = tbl[i].blz;
      step(1'b1, tbl[i].word, tbl[i].dpv);
      for (int k = 0; k < 4 * tbl[i].slot; k++) step(1'b0, 16'h0, 4'h0);
      chk("tbl_sel", digit_sel, tbl[i].sel);
      chk("tbl_nib", {w, x, y, z}, tbl[i].nib);
      chk("tbl_dp", dp, tbl[i].dpo);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        blank_lz = ~blank_lz;
        #1;
        check_model();
      end
      r = 16'($urandom);
      r = r >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 7) == 0, r, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
